aes_inv_round_ctrl: RTL and testbench
=====================================

# aes_inv_round_ctrl

Iterative AES-128 decryption controller. Accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over 10 rounds, one round per clock. It fetches round keys by index from the key-schedule store. It returns the plaintext over a second valid/ready handshake. It sits between the block-cipher front end and the expanded-key RAM.

## Interface
Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  controller can accept a block.
- ciphertext  in  128  input block; byte 0 at [127:120], column-major.
- rk_idx  out  4  round-key index request, range 0..10.
- rk  in  128  round key for rk_idx; combinational, valid in the same cycle.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts plaintext.
- plaintext  out  128  result block, same byte order as ciphertext.
- busy  out  1  high in ROUND and FINAL.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE
  - in_ready=1, rk_idx=10.
  - On in_valid: st <= ciphertext ^ rk, rnd <= 9, go to ROUND.
- ROUND
  - rk_idx=rnd.
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk).
  - rnd <= rnd-1.
  - When rnd==1, go to FINAL.
- FINAL
  - rk_idx=0.
  - st <= InvSubBytes(InvShiftRows(st)) ^ rk, with no InvMixColumns.
  - Go to DONE.
- DONE
  - out_valid=1 and plaintext=st, both held stable until out_ready.
  - On out_ready, go to IDLE.
  - rk_idx=0.
- plaintext is driven from st in every state; it is meaningful only while out_valid=1.
- in_valid while not in_ready is ignored. ciphertext is sampled only on the accept edge.
- rnd is a 4-bit counter. It never wraps: its minimum value is 1 in ROUND.
- Reset (asynchronous, any state, including mid-round): state=IDLE, st=0, rnd=0, out_valid=0, busy=0. in_ready=1 after reset. A block in flight is discarded with no partial output.

## Timing
- Accept edge E0, then ROUND at edges E1..E9, then FINAL at E10.
- out_valid is high in the cycle after E10: 10-cycle latency from the accept edge.
- With out_ready held high, DONE lasts 1 cycle, so the block period is 12 cycles (11 with the macro below).
- rk is consumed on the same edge as rk_idx; the key store must be combinational or a pre-registered lookahead.
- Outputs in_ready, out_valid, busy and rk_idx decode from registered state only. There is no combinational path from in_valid/out_ready to outputs, except in_ready under the macro below.

## Configuration
- AES_DEC_FAST_ACCEPT_EN: defined
  - In DONE, in_ready = out_ready.
  - If out_ready and in_valid are both high, the output is retired and the new block is loaded (st <= ciphertext ^ rk with rk_idx=10) on the same edge, going directly to ROUND.
  - rk_idx in DONE is 10.
  - Period drops to 11 cycles.
- AES_DEC_FAST_ACCEPT_EN: undefined
  - in_ready is high only in IDLE; rk_idx in DONE is 0.

## Structure
- Shared package aes_pkg holds:
  - state enum (IDLE/ROUND/FINAL/DONE)
  - NR=10
  - the byte typedef and the 16-entry byte-array typedef
  - the column-major pack/unpack functions, byte i = [127-8i -: 8]
  - the InvSBox function and the gf_mul2/gf_mul3 helpers
- One sub-module: aes_inv_round. It is combinational: st, rk and a final flag in, next state out. It contains the InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns stages, with InvMixColumns bypassed when final=1.
- The controller holds the FSM, the rnd counter, the st register and the handshakes.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key store), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after accept.
- rk_idx trace over one block -> 10, 9, 8, …, 1, 0, then 0 (10 with the macro) in DONE; busy high for exactly 10 cycles.
- out_ready held low 5 cycles in DONE -> out_valid and plaintext stable; in_ready=0; a new in_valid is not accepted.
- in_valid pulsed during ROUND with a different ciphertext -> ignored; the original plaintext is still correct.
- rst_n asserted at E5 -> immediately IDLE, out_valid=0, st=0. The next block (C.1 vector) decrypts correctly.
- Back-to-back, with the macro defined: two C.1 blocks, out_ready and in_valid held high -> second out_valid 11 cycles after the first. Without the macro: 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption types and helpers: FSM states, byte/block views, inverse S-box, GF(2^8) multiply.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  typedef logic [7:0]       byte_t;
  typedef byte_t [0:15]     bytes_t;

  // Entry n is InvSBox(n); entry 0 sits in the top byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic bytes_t unpack_blk(logic [127:0] blk);
    bytes_t b;
    for (int i = 0; i < 16; i++) b[i] = blk[127-8*i -: 8];
    return b;
  endfunction

  function automatic logic [127:0] pack_blk(bytes_t b);
    logic [127:0] blk;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = b[i];
    return blk;
  endfunction

  function automatic byte_t inv_sbox(byte_t a);
    return INV_SBOX[a];
  endfunction

  function automatic byte_t gf_mul2(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul3(byte_t a);
    return gf_mul2(a) ^ a;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless i_final is set (last round skips the column mix).
module aes_inv_round (
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  input  logic         i_final,
  output logic [127:0] o_st
);
  import aes_pkg::*;

  bytes_t       w_in;
  bytes_t       w_sub;
  bytes_t       w_ark;
  bytes_t       w_mix;
  byte_t        w_x2, w_x4, w_x8;
  bytes_t       w_m9, w_mb, w_md, w_me;
  logic [127:0] w_ark_blk;

  always_comb begin
    w_in = unpack_blk(i_st);
    // Byte (row r, col c) lives at index r+4c; row r is rotated right by r columns.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w_sub[r+4*c] = inv_sbox(w_in[r + 4*((c - r + 4) % 4)]);
    w_ark_blk = pack_blk(w_sub) ^ i_rk;
    w_ark     = unpack_blk(w_ark_blk);

    w_x2 = '0;
    w_x4 = '0;
    w_x8 = '0;
    for (int i = 0; i < 16; i++) begin
      w_x2    = gf_mul2(w_ark[i]);
      w_x4    = gf_mul2(w_x2);
      w_x8    = gf_mul2(w_x4);
      w_m9[i] = w_x8 ^ w_ark[i];
      w_mb[i] = w_x8 ^ gf_mul3(w_ark[i]);
      w_md[i] = w_x8 ^ w_x4 ^ w_ark[i];
      w_me[i] = w_x8 ^ w_x4 ^ w_x2;
    end

    for (int c = 0; c < 4; c++) begin
      w_mix[4*c+0] = w_me[4*c] ^ w_mb[4*c+1] ^ w_md[4*c+2] ^ w_m9[4*c+3];
      w_mix[4*c+1] = w_m9[4*c] ^ w_me[4*c+1] ^ w_mb[4*c+2] ^ w_md[4*c+3];
      w_mix[4*c+2] = w_md[4*c] ^ w_m9[4*c+1] ^ w_me[4*c+2] ^ w_mb[4*c+3];
      w_mix[4*c+3] = w_mb[4*c] ^ w_md[4*c+1] ^ w_m9[4*c+2] ^ w_me[4*c+3];
    end

    o_st = i_final ? w_ark_blk : pack_blk(w_mix);
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock, plaintext valid 10 cycles after accept.
// AES_DEC_FAST_ACCEPT_EN: DONE may retire its result and accept the next block on the same edge.
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  import aes_pkg::*;

`ifdef AES_DEC_FAST_ACCEPT_EN
  localparam logic [3:0] DONE_RK = 4'(NR);
`else
  localparam logic [3:0] DONE_RK = 4'd0;
`endif

  state_t       r_state;
  logic [127:0] r_st;
  logic [3:0]   r_rnd;
  logic [3:0]   r_rk_idx;
  logic         r_in_rdy;
  logic         r_out_vld;
  logic         r_busy;
  logic [127:0] w_round;

  aes_inv_round u_round (
    .i_st    (r_st),
    .i_rk    (rk),
    .i_final (r_state == FINAL),
    .o_st    (w_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_st      <= '0;
      r_rnd     <= '0;
      r_rk_idx  <= 4'(NR);
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st     <= ciphertext ^ rk;
            r_rnd    <= 4'(NR - 1);
            r_rk_idx <= 4'(NR - 1);
            r_in_rdy <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ROUND;
          end
        end
        ROUND: begin
          r_st  <= w_round;
          r_rnd <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) begin
            r_rk_idx <= 4'd0;
            r_state  <= FINAL;
          end else begin
            r_rk_idx <= r_rnd - 4'd1;
          end
        end
        FINAL: begin
          r_st      <= w_round;
          r_rk_idx  <= DONE_RK;
          r_busy    <= 1'b0;
          r_out_vld <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
`ifdef AES_DEC_FAST_ACCEPT_EN
          // rk already points at the last round key, so the next block loads directly.
          if (out_ready && in_valid) begin
            r_st      <= ciphertext ^ rk;
            r_rnd     <= 4'(NR - 1);
            r_rk_idx  <= 4'(NR - 1);
            r_out_vld <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ROUND;
          end else if (out_ready) begin
            r_rk_idx  <= 4'(NR);
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
`else
          if (out_ready) begin
            r_rk_idx  <= 4'(NR);
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AES_DEC_FAST_ACCEPT_EN
  assign in_ready = r_in_rdy | ((r_state == DONE) & out_ready);
`else
  assign in_ready = r_in_rdy;
`endif
  assign out_valid = r_out_vld;
  assign busy      = r_busy;
  assign rk_idx    = r_rk_idx;
  assign plaintext = r_st;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the FIPS-197 C.1 vector and a combinational key store.
`timescale 1ns/1ps
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ALT = 128'hdeadbeef0123456789abcdeffedcba98;
`ifdef AES_DEC_FAST_ACCEPT_EN
  localparam int DONE_RK = 10;
  localparam int PERIOD  = 11;
`else
  localparam int DONE_RK = 0;
  localparam int PERIOD  = 12;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  logic [127:0] rk_tab [0:15];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rk = rk_tab[rk_idx];

  aes_inv_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until out_valid is seen; lat counts edges since the accept edge.
  task automatic wait_out(input int start_lat, output int lat);
    lat = start_lat;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, n, first, second;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0;

    repeat (2) tick();
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rk_idx",    128'(rk_idx),    128'(10));
    chk("rst_plaintext", plaintext,       128'(0));
    rst_n = 1'b1;
    tick();

    // Single block with out_ready low: rk_idx/busy/out_valid trace per edge.
    chk("idle_rk_idx", 128'(rk_idx), 128'(10));
    in_valid = 1'b1; ciphertext = CT;
    tick();
    in_valid = 1'b0; ciphertext = ALT;
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("trace_rk_idx[%0d]", i), 128'(rk_idx),
          128'((i <= 8) ? 9 - i : (i == 9 ? 0 : DONE_RK)));
      chk($sformatf("trace_busy[%0d]", i),      128'(busy),      128'(i < 10));
      chk($sformatf("trace_out_valid[%0d]", i), 128'(out_valid), 128'(i == 10));
      if (i < 10) tick();
    end
    chk("c1_plaintext", plaintext, PT);

    // Stall in DONE with a competing in_valid.
    in_valid = 1'b1; ciphertext = ALT;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_out_valid[%0d]", i), 128'(out_valid), 128'(1));
      chk($sformatf("hold_plaintext[%0d]", i), plaintext,       PT);
      chk($sformatf("hold_in_ready[%0d]", i),  128'(in_ready),  128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("retire_out_valid", 128'(out_valid), 128'(0));
    chk("retire_in_ready",  128'(in_ready),  128'(1));
    chk("retire_rk_idx",    128'(rk_idx),    128'(10));

    // in_valid pulse during ROUND must not disturb the block in flight.
    in_valid = 1'b1; ciphertext = CT;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; ciphertext = ALT;
    repeat (2) tick();
    in_valid = 1'b0;
    wait_out(5, lat);
    chk("pulse_latency",   128'(lat), 128'(10));
    chk("pulse_plaintext", plaintext, PT);
    tick();
    chk("pulse_idle", 128'(in_ready), 128'(1));

    // Reset mid-round after E5.
    in_valid = 1'b1; ciphertext = CT;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy",      128'(busy),      128'(0));
    chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
    chk("mid_rst_rk_idx",    128'(rk_idx),    128'(10));
    chk("mid_rst_st",        plaintext,       128'(0));
    #2;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; ciphertext = CT;
    tick();
    in_valid = 1'b0;
    wait_out(0, lat);
    chk("post_rst_latency",   128'(lat), 128'(10));
    chk("post_rst_plaintext", plaintext, PT);
    tick();

    // Back-to-back blocks with both handshakes held high.
    in_valid = 1'b1; ciphertext = CT; out_ready = 1'b1;
    n = 0; first = -1; second = -1;
    while (second < 0 && n < 60) begin
      tick();
      n++;
      if (out_valid) begin
        if (first < 0) begin
          first = n;
          chk("b2b_pt0", plaintext, PT);
        end else begin
          second = n;
          chk("b2b_pt1", plaintext, PT);
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_first_latency", 128'(first - 1),      128'(10));
    chk("b2b_period",        128'(second - first), 128'(PERIOD));
    repeat (2) tick();
    chk("b2b_end_idle", 128'(in_ready), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
